// File: rtl/pipe_decode.sv
// pipe_decode: single-stage instruction decoder with valid/ready output,
// register scoreboard for RAW/WAW hazards, halt latch and pipeline flush.
module pipe_decode #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter bit SEXT   = 1'b1,
    parameter bit SB_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [3:0]        wb_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        op_class,
    output logic              special,
    output logic              set_flags,
    output logic [2:0]        alu_fn,
    output logic [3:0]        sub_op,
    output logic [3:0]        br_cond,
    output logic [3:0]        rd,
    output logic [3:0]        rs1,
    output logic [3:0]        rs2,
    output logic [DATA_W-1:0] imm_ext,
    output logic              reg_write,
    output logic              rd_rs1,
    output logic              rd_rs2,
    output logic              is_halt,
    output logic              halted
);

    typedef struct packed {
        logic [1:0]        opClass;
        logic              special;
        logic              setFlags;
        logic [2:0]        aluFn;
        logic [3:0]        subOp;
        logic [3:0]        brCond;
        logic [3:0]        rd;
        logic [3:0]        rs1;
        logic [3:0]        rs2;
        logic [DATA_W-1:0] imm;
        logic              regWrite;
        logic              rdRs1;
        logic              rdRs2;
        logic              isHalt;
    } decT;

    decT               dec;
    decT               outQ;
    logic              outValidQ;
    logic              haltedQ;
    logic [15:0]       pend;
    logic              hazard;
    logic              stall;
    logic              accept;
    logic [IMM_W-1:0]  immRaw;
    logic [DATA_W-1:0] immExt;

    assign immRaw = instr[IMM_W-1:0];
    assign immExt = SEXT ? {{(DATA_W-IMM_W){immRaw[IMM_W-1]}}, immRaw}
                         : {{(DATA_W-IMM_W){1'b0}}, immRaw};

    // Decode the incoming word; class selects register usage
    always_comb begin
        dec          = '0;
        dec.opClass  = instr[31:30];
        dec.special  = instr[29];
        dec.subOp    = instr[28:25];
        dec.setFlags = instr[28];
        dec.aluFn    = instr[27:25];
        dec.rd       = instr[24:21];
        dec.rs1      = instr[20:17];
        dec.rs2      = instr[16:13];
        dec.imm      = immExt;
        dec.isHalt   = (instr[31:25] == 7'b1101000);
        unique case (instr[31:30])
            2'b11: begin
                dec.brCond   = instr[24:21];
                dec.rd       = 4'd0;
                dec.regWrite = 1'b0;
                dec.rdRs1    = 1'b1;
                dec.rdRs2    = 1'b1;
            end
            2'b10: begin
                dec.rs2      = 4'd0;
                dec.rdRs1    = 1'b1;
                dec.regWrite = ~instr[28];
                dec.rdRs2    = instr[28];
            end
            2'b01: begin
                dec.regWrite = 1'b1;
                dec.rdRs1    = 1'b1;
                dec.rdRs2    = 1'b1;
            end
            2'b00: begin
                dec.rs2      = 4'd0;
                dec.regWrite = 1'b1;
                dec.rdRs1    = 1'b1;
                dec.rdRs2    = 1'b0;
            end
        endcase
    end

    assign hazard = (dec.rdRs1 & pend[dec.rs1])
                  | (dec.rdRs2 & pend[dec.rs2])
                  | (dec.regWrite & pend[dec.rd]);
    assign stall    = SB_EN & in_valid & hazard;
    assign in_ready = rst & ~flush & ~haltedQ & ~stall
                    & (~outValidQ | out_ready);
    assign accept   = in_valid & in_ready;

    // Output stage: load on accept, drop valid once consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outValidQ <= 1'b0;
            outQ      <= '0;
            haltedQ   <= 1'b0;
        end else if (flush) begin
            outValidQ <= 1'b0;
            haltedQ   <= 1'b0;
        end else begin
            if (accept) begin
                outValidQ <= 1'b1;
                outQ      <= dec;
            end else if (out_ready) begin
                outValidQ <= 1'b0;
            end
            if (accept && dec.isHalt) begin
                haltedQ <= 1'b1;
            end
        end
    end

    if (SB_EN) begin : gSb
        logic [15:0] setMask;
        logic [15:0] clrMask;

        // One-hot set/clear masks for this cycle
        always_comb begin
            setMask = '0;
            clrMask = '0;
            if (accept && dec.regWrite) setMask[dec.rd] = 1'b1;
            if (wb_valid)               clrMask[wb_rd]  = 1'b1;
        end

        // Pending bits; a same-cycle set overrides the clear
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pend <= '0;
            end else if (flush) begin
                pend <= '0;
            end else begin
                pend <= (pend & ~clrMask) | setMask;
            end
        end
    end else begin : gNoSb
        assign pend = '0;
    end

    assign out_valid = outValidQ;
    assign halted    = haltedQ;
    assign op_class  = outQ.opClass;
    assign special   = outQ.special;
    assign set_flags = outQ.setFlags;
    assign alu_fn    = outQ.aluFn;
    assign sub_op    = outQ.subOp;
    assign br_cond   = outQ.brCond;
    assign rd        = outQ.rd;
    assign rs1       = outQ.rs1;
    assign rs2       = outQ.rs2;
    assign imm_ext   = outQ.imm;
    assign reg_write = outQ.regWrite;
    assign rd_rs1    = outQ.rdRs1;
    assign rd_rs2    = outQ.rdRs2;
    assign is_halt   = outQ.isHalt;

endmodule

// File: tb/tb_pipe_decode.sv
// tb_pipe_decode: directed vectors for pipe_decode with hand-computed
// expectations; a second instance checks zero-extension.
module tb_pipe_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [31:0] instr;
    logic        flush;
    logic        wbValid;
    logic [3:0]  wbRd;
    logic        outReady;

    logic        inReady, outValid, special, setFlags, regWrite;
    logic        rdRs1, rdRs2, isHalt, halted;
    logic [1:0]  opClass;
    logic [2:0]  aluFn;
    logic [3:0]  subOp, brCond, rd, rs1, rs2;
    logic [31:0] immExt;

    logic        zInReady, zOutValid, zSpecial, zSetFlags, zRegWrite;
    logic        zRdRs1, zRdRs2, zIsHalt, zHalted;
    logic [1:0]  zOpClass;
    logic [2:0]  zAluFn;
    logic [3:0]  zSubOp, zBrCond, zRd, zRs1, zRs2;
    logic [31:0] zImmExt;

    int total = 0;
    int bad   = 0;

    pipe_decode dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .instr(instr), .flush(flush), .wb_valid(wbValid), .wb_rd(wbRd),
        .out_valid(outValid), .out_ready(outReady), .op_class(opClass),
        .special(special), .set_flags(setFlags), .alu_fn(aluFn),
        .sub_op(subOp), .br_cond(brCond), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm_ext(immExt), .reg_write(regWrite), .rd_rs1(rdRs1),
        .rd_rs2(rdRs2), .is_halt(isHalt), .halted(halted)
    );

    pipe_decode #(.SEXT(1'b0)) dutZ (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(zInReady),
        .instr(instr), .flush(flush), .wb_valid(wbValid), .wb_rd(wbRd),
        .out_valid(zOutValid), .out_ready(outReady), .op_class(zOpClass),
        .special(zSpecial), .set_flags(zSetFlags), .alu_fn(zAluFn),
        .sub_op(zSubOp), .br_cond(zBrCond), .rd(zRd), .rs1(zRs1),
        .rs2(zRs2), .imm_ext(zImmExt), .reg_write(zRegWrite),
        .rd_rs1(zRdRs1), .rd_rs2(zRdRs2), .is_halt(zIsHalt),
        .halted(zHalted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [1:0] c,
                                       input logic [3:0] sub,
                                       input logic [3:0] d,
                                       input logic [3:0] s1,
                                       input logic [3:0] s2,
                                       input logic [12:0] lo);
        return {c, 1'b0, sub, d, s1, s2, lo};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] iA, iB, iC, iW, iR, iR2, iHalt, iX, iBr, iSt;
        logic [31:0] iY, iZ;
        iA    = mk(2'b01, 4'h0, 4'd5, 4'd6, 4'd7, 13'h0);
        iB    = mk(2'b01, 4'h0, 4'd8, 4'd9, 4'd10, 13'h0);
        iC    = mk(2'b01, 4'h0, 4'd11, 4'd12, 4'd13, 13'h0);
        iW    = mk(2'b00, 4'h0, 4'd3, 4'd2, 4'd0, 13'h5);
        iR    = mk(2'b01, 4'h0, 4'd4, 4'd3, 4'd2, 13'h0);
        iR2   = mk(2'b01, 4'h0, 4'd14, 4'd3, 4'd2, 13'h0);
        iHalt = 32'hD000_0000;
        iX    = mk(2'b00, 4'h0, 4'd6, 4'd7, 4'd0, 13'h0);
        iBr   = mk(2'b11, 4'h0, 4'd5, 4'd3, 4'd4, 13'h0);
        iSt   = mk(2'b10, 4'h8, 4'd2, 4'd5, 4'd9, 13'h10);
        iY    = mk(2'b01, 4'h0, 4'd9, 4'd1, 4'd2, 13'h0);
        iZ    = mk(2'b01, 4'h0, 4'd6, 4'd9, 4'd1, 13'h0);

        rst = 1'b0; inValid = 1'b0; instr = '0; flush = 1'b0;
        wbValid = 1'b0; wbRd = '0; outReady = 1'b0;
        #3;
        chk("rst_ov", outValid, 0);
        chk("rst_ir", inReady, 0);
        chk("rst_halted", halted, 0);
        chk("rst_imm", immExt, 0);
        tick();
        rst = 1'b1;

        // reg-imm decode and extension
        inValid = 1'b1; instr = 32'h0028_FFFF; outReady = 1'b1;
        #1 chk("t1_ir", inReady, 1);
        tick();
        inValid = 1'b0; wbValid = 1'b1; wbRd = 4'd1;
        #1;
        chk("t1_ov", outValid, 1);
        chk("t1_rd", rd, 1);
        chk("t1_rs1", rs1, 4);
        chk("t1_rs2", rs2, 0);
        chk("t1_imm_s", immExt, 32'hFFFF_FFFF);
        chk("t1_imm_z", zImmExt, 32'h0000_FFFF);
        chk("t1_rw", regWrite, 1);
        chk("t1_rdrs2", rdRs2, 0);
        chk("t1_brc", brCond, 0);
        tick();
        wbValid = 1'b0;
        chk("t1_ov_drop", outValid, 0);

        // back-to-back with backpressure
        inValid = 1'b1; instr = iA;
        tick();
        instr = iB;
        #1;
        chk("t2_a_rd", rd, 5);
        chk("t2_a_ir", inReady, 1);
        tick();
        instr = iC; outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_hold_rd", rd, 8);
            chk("t2_hold_ov", outValid, 1);
            chk("t2_hold_ir", inReady, 0);
            tick();
        end
        outReady = 1'b1;
        #1 chk("t2_rel_ir", inReady, 1);
        tick();
        inValid = 1'b0;
        #1;
        chk("t2_c_rd", rd, 11);
        chk("t2_c_ov", outValid, 1);
        tick();
        chk("t2_c_gone", outValid, 0);

        // RAW hazard on r3
        inValid = 1'b1; instr = iW;
        tick();
        instr = iR;
        #1 chk("t3_stall0", inReady, 0);
        tick();
        wbValid = 1'b1; wbRd = 4'd3;
        #1 chk("t3_stall1", inReady, 0);
        chk("t3_ov_idle", outValid, 0);
        tick();
        wbValid = 1'b0;
        #1 chk("t3_free", inReady, 1);
        tick();
        instr = iW; wbValid = 1'b1; wbRd = 4'd3;
        #1;
        chk("t3_r_ov", outValid, 1);
        chk("t3_r_rd", rd, 4);
        chk("t3_r_rs1", rs1, 3);
        chk("t3_w2_ir", inReady, 1);
        tick();
        instr = iR2; wbValid = 1'b0;
        #1 chk("t3_setwins", inReady, 0);
        inValid = 1'b0;
        tick();

        // halt then flush
        inValid = 1'b1; instr = iHalt;
        #1 chk("t4_ir", inReady, 1);
        tick();
        instr = iX; outReady = 1'b0;
        #1;
        chk("t4_ishalt", isHalt, 1);
        chk("t4_ov", outValid, 1);
        chk("t4_halted", halted, 1);
        chk("t4_ir_lo", inReady, 0);
        chk("t4_class", opClass, 3);
        tick();
        chk("t4_hold", isHalt, 1);
        chk("t4_ir_lo2", inReady, 0);
        flush = 1'b1; outReady = 1'b0;
        #1 chk("t4_fl_ir", inReady, 0);
        tick();
        flush = 1'b0; outReady = 1'b1; instr = iBr;
        #1;
        chk("t4_fl_ov", outValid, 0);
        chk("t4_fl_halt", halted, 0);
        chk("t4_fl_pend", inReady, 1);
        tick();
        instr = iSt;
        #1;
        chk("t4_br_cond", brCond, 5);
        chk("t4_br_rd", rd, 0);
        chk("t4_br_rw", regWrite, 0);
        chk("t4_br_rs2", rs2, 4);
        chk("t4_br_halt", isHalt, 0);
        tick();
        inValid = 1'b0;
        #1;
        chk("t4_st_rw", regWrite, 0);
        chk("t4_st_rdrs2", rdRs2, 1);
        chk("t4_st_rs2", rs2, 0);
        chk("t4_st_sf", setFlags, 1);
        chk("t4_st_sub", subOp, 8);
        chk("t4_st_imm", immExt, 32'h0000_2010);
        tick();

        // reset while output is held
        inValid = 1'b1; instr = iY; outReady = 1'b0;
        tick();
        inValid = 1'b0;
        #1 chk("t5_pre_ov", outValid, 1);
        rst = 1'b0;
        #1;
        chk("t5_ov", outValid, 0);
        chk("t5_rd", rd, 0);
        chk("t5_rw", regWrite, 0);
        chk("t5_ir", inReady, 0);
        tick();
        rst = 1'b1; inValid = 1'b1; instr = iZ; outReady = 1'b1;
        #1 chk("t5_pend_clr", inReady, 1);
        tick();
        inValid = 1'b0;
        #1;
        chk("t5_acc_ov", outValid, 1);
        chk("t5_acc_rd", rd, 6);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_decode.md
PIPE_DECODE -- requirements
Module: pipe_decode

Interface
REQ-001 SHALL provide parameter IMM_W, default 16: immediate field width taken from instr[IMM_W-1:0]; legal range 8..16.
REQ-002 SHALL provide parameter DATA_W, default 32: width of the extended immediate output.
REQ-003 SHALL provide parameter SEXT, default 1: 1 = sign-extend immediate, 0 = zero-extend.
REQ-004 SHALL provide parameter SB_EN, default 1: 1 = register scoreboard active, 0 = never stall on hazards.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-low reset (one clock, all state on rising clk).
REQ-006 SHALL have ports: in_valid in 1; in_ready out 1; instr in 32 instruction word.
REQ-007 SHALL have ports: flush in 1 pipeline flush; wb_valid in 1; wb_rd in 4 writeback completion.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; op_class out 2; special out 1; set_flags out 1; alu_fn out 3; sub_op out 4.
REQ-009 SHALL have ports: br_cond out 4; rd out 4; rs1 out 4; rs2 out 4; imm_ext out DATA_W; reg_write out 1; rd_rs1 out 1; rd_rs2 out 1; is_halt out 1; halted out 1.

Function
REQ-010 SHALL decode: op_class=instr[31:30], special=[29], sub_op=[28:25], set_flags=[28], alu_fn=[27:25], br_cond/rd=[24:21], rs1=[20:17], rs2=[16:13].
REQ-011 SHALL set is_halt when instr[31:25]==7'b1101000.
REQ-012 SHALL set per class: 11 branch: rd=0, reg_write=0, rd_rs1=rd_rs2=1; 10 load/store: rs2=0, rd_rs1=1, reg_write=~instr[28], rd_rs2=instr[28]; 01 reg-reg: reg_write=rd_rs1=rd_rs2=1; 00 reg-imm: rs2=0, reg_write=rd_rs1=1, rd_rs2=0.
REQ-013 SHALL present imm_ext = instr[IMM_W-1:0] extended to DATA_W per SEXT; br_cond SHALL be 0 unless op_class==11.
REQ-014 SHALL register all decoded outputs in one output stage; latency in-accept to out_valid = 1 cycle.
REQ-015 SHALL drive in_ready = ~halted & ~stall & (~out_valid | out_ready), combinationally.
REQ-016 SHALL accept an instruction only when in_valid & in_ready; out_valid SHALL then be 1 next cycle.
REQ-017 SHALL hold all output fields stable while out_valid & ~out_ready; out_valid SHALL drop after a handshake with no new accept.
REQ-018 SHALL keep a 16-bit pending scoreboard (SB_EN=1); stall = in_valid & (rd_rs1&pend[rs1] | rd_rs2&pend[rs2] | reg_write&pend[rd]), using decode of the incoming instr.
REQ-019 SHALL set pend[rd] on accept when reg_write; SHALL clear pend[wb_rd] on wb_valid; same register set and cleared same cycle -> set wins.
REQ-020 SHALL evaluate stall from registered pend only (a clear is visible one cycle after wb_valid; no bypass).
REQ-021 SHALL set halted on accept of a halt instruction; while halted, in_ready=0; halt itself SHALL still be emitted on the output.
REQ-022 SHALL on flush (synchronous, highest priority): out_valid<=0, pend<=0, halted<=0, no accept that cycle (in_ready=0 while flush=1).
REQ-023 SHALL with SB_EN=0 force stall=0 and pend constant 0.

Reset
REQ-024 SHALL on rst low, immediately: out_valid=0, halted=0, pend=0, every registered output field=0; in_ready=0 while rst low.
REQ-025 SHALL on rst mid-transfer drop the held instruction without emitting it; first accept possible on the first clk edge after rst deasserts.

Verification
REQ-026 SHALL verify: reg-imm 0x0028_FFFF, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=4, imm_ext=0xFFFF_FFFF (SEXT=1) / 0x0000_FFFF (SEXT=0), reg_write=1.
REQ-027 SHALL verify: back-to-back accepts, out_ready=0 for 3 cycles -> in_ready=0, outputs frozen, no loss or duplication after release.
REQ-028 SHALL verify: write r3 then read r3 -> second stalls until wb_valid,wb_rd=3, accepted one cycle after the clear; same-cycle set/clear of r3 leaves pend[3]=1.
REQ-029 SHALL verify: halt 0xD000_0000 accepted -> is_halt=1 emitted, halted=1, in_ready=0 thereafter; flush -> halted=0, pend=0, out_valid=0.
REQ-030 SHALL verify: rst low while out_valid=1 & out_ready=0 -> out_valid=0 immediately, all outputs 0, pend cleared.
